// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
//
// Shared definitions for the modulo counter family.
//   CNT_MAX_W      widest counter supported; sizes the next-state struct so a
//                  single packed type serves every WIDTH instance.
//   CNT_MODE_WRAP  wrap at the ends of the count range.
//   CNT_MODE_SAT   hold at the ends of the count range.
//   cnt_next_t     next-state result: next count value plus the wrap and
//                  overflow events that the edge will register.
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam int CNT_MAX_W     = 32;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    typedef struct packed {
        logic [CNT_MAX_W-1:0] next_q;    // next count, zero-extended to CNT_MAX_W
        logic                 wrap_evt;  // count crossed an end of the range
        logic                 ovf_evt;   // wrap, blocked step or out-of-range load
    } cnt_next_t;

endpackage

// File: rtl/mod_counter_next.sv
// ----------------------------------------------------------------------------
// mod_counter_next
//
// Combinational next-state function of the modulo counter.
//   Parameters: WIDTH, MODULUS, SATURATE (CNT_MODE_WRAP / CNT_MODE_SAT)
//   Inputs : q        current count
//            en       count enable
//            up       direction, 1 = increment
//            load     load strobe, beats en
//            load_val value to load
//   Output : nxt      next count plus wrap/overflow events
//
// All compares and arithmetic use WIDTH+1 bits so that MODULUS = 2^WIDTH
// (last value = all ones) needs no special casing.
// ----------------------------------------------------------------------------
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output cnt_next_t        nxt
);

    localparam longint unsigned LAST_L   = MODULUS - 64'd1;
    localparam logic [WIDTH:0]  LAST     = LAST_L[WIDTH:0];
    localparam bit              SAT_MODE = (SATURATE == CNT_MODE_SAT);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] load_ext;
    logic [WIDTH:0] next_ext;
    logic           wrap_evt;
    logic           ovf_evt;

    assign q_ext    = {1'b0, q};
    assign load_ext = {1'b0, load_val};

    always_comb begin
        next_ext = q_ext;
        wrap_evt = 1'b0;
        ovf_evt  = 1'b0;

        if (load) begin
            // Out-of-range loads clamp to the last legal value.
            if (load_ext <= LAST) begin
                next_ext = load_ext;
            end else begin
                next_ext = LAST;
                ovf_evt  = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (q_ext < LAST) begin
                    next_ext = q_ext + 1'b1;
                end else begin
                    ovf_evt = 1'b1;
                    if (!SAT_MODE) begin
                        next_ext = '0;
                        wrap_evt = 1'b1;
                    end
                end
            end else begin
                if (q_ext != '0) begin
                    next_ext = q_ext - 1'b1;
                end else begin
                    ovf_evt = 1'b1;
                    if (!SAT_MODE) begin
                        next_ext = LAST;
                        wrap_evt = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        nxt          = '0;
        // The extra top bit is always 0 here; the cast just re-sizes.
        nxt.next_q   = CNT_MAX_W'(next_ext);
        nxt.wrap_evt = wrap_evt;
        nxt.ovf_evt  = ovf_evt;
    end

endmodule

// File: rtl/mod_counter.sv
// ----------------------------------------------------------------------------
// mod_counter
//
// Parametrised synchronous modulo counter (0..MODULUS-1) with up/down,
// synchronous load, enable, wrap or saturate mode, terminal count for
// cascading and a sticky overflow flag.
//   Parameters: WIDTH (1..32), MODULUS (2..2^WIDTH), SATURATE (0 wrap, 1 sat)
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   en        count enable
//   up        direction, 1 = increment
//   load      synchronous load, priority over en
//   load_val  value to load (clamped to MODULUS-1 with ovf if too large)
//   clr_ovf   synchronous clear of ovf (a same-edge set wins)
//   q         registered count
//   tc        combinational terminal count, feeds the next stage's en
//   wrap      registered one-cycle pulse alongside the wrapped value
//   ovf       registered sticky overflow
// ----------------------------------------------------------------------------
module mod_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = CNT_MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam longint unsigned LAST_L = MODULUS - 64'd1;
    localparam logic [WIDTH:0]  LAST   = LAST_L[WIDTH:0];

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_q;
    logic             ovf_d;
    cnt_next_t        nxt;
    logic             unused_next_bits;

    mod_counter_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .q        (q_q),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .nxt      (nxt)
    );

    // Upper struct bits beyond WIDTH are always zero.
    assign unused_next_bits = ^nxt.next_q;

    always_comb begin
        q_d    = nxt.next_q[WIDTH-1:0];
        wrap_d = nxt.wrap_evt;
        // Set beats clear when both land on the same edge.
        if (nxt.ovf_evt) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // Unregistered so a cascade of stages advances on the same edge.
    assign tc   = en & (up ? ({1'b0, q_q} == LAST) : (q_q == '0));

    assign q    = q_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_mod_counter
//
// Directed bench for mod_counter. Three instances share clock and reset:
//   dut_w  WIDTH=4 MODULUS=10 wrap mode
//   dut_s  WIDTH=4 MODULUS=10 saturate mode
//   dut_p  WIDTH=3 MODULUS=8  wrap mode (modulus equals 2^WIDTH)
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_mod_counter;

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- dut_w signals ----------------
    logic       en_w = 0, up_w = 1, load_w = 0, clr_w = 0;
    logic [3:0] lv_w = '0;
    logic [3:0] q_w;
    logic       tc_w, wrap_w, ovf_w;

    // ---------------- dut_s signals ----------------
    logic       en_s = 0, up_s = 1, load_s = 0, clr_s = 0;
    logic [3:0] lv_s = '0;
    logic [3:0] q_s;
    logic       tc_s, wrap_s, ovf_s;

    // ---------------- dut_p signals ----------------
    logic       en_p = 0, up_p = 1, load_p = 0, clr_p = 0;
    logic [2:0] lv_p = '0;
    logic [2:0] q_p;
    logic       tc_p, wrap_p, ovf_p;

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .en(en_w), .up(up_w), .load(load_w),
        .load_val(lv_w), .clr_ovf(clr_w), .q(q_w), .tc(tc_w), .wrap(wrap_w),
        .ovf(ovf_w)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .en(en_s), .up(up_s), .load(load_s),
        .load_val(lv_s), .clr_ovf(clr_s), .q(q_s), .tc(tc_s), .wrap(wrap_s),
        .ovf(ovf_s)
    );

    mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) dut_p (
        .clk(clk), .reset(reset), .en(en_p), .up(up_p), .load(load_p),
        .load_val(lv_p), .clr_ovf(clr_p), .q(q_p), .tc(tc_p), .wrap(wrap_p),
        .ovf(ovf_p)
    );

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input int eq, input bit ew, input bit eo);
        chk({tag, " w.q"},    32'(q_w),    32'(eq));
        chk({tag, " w.wrap"}, 32'(wrap_w), 32'(ew));
        chk({tag, " w.ovf"},  32'(ovf_w),  32'(eo));
    endtask

    task automatic chk_s(input string tag, input int eq, input bit ew, input bit eo);
        chk({tag, " s.q"},    32'(q_s),    32'(eq));
        chk({tag, " s.wrap"}, 32'(wrap_s), 32'(ew));
        chk({tag, " s.ovf"},  32'(ovf_s),  32'(eo));
    endtask

    task automatic chk_p(input string tag, input int eq, input bit ew, input bit eo);
        chk({tag, " p.q"},    32'(q_p),    32'(eq));
        chk({tag, " p.wrap"}, 32'(wrap_p), 32'(ew));
        chk({tag, " p.ovf"},  32'(ovf_p),  32'(eo));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state, before any clock edge.
        #2;
        chk_w("reset", 0, 0, 0);
        chk_s("reset", 0, 0, 0);
        chk_p("reset", 0, 0, 0);
        chk("reset w.tc", 32'(tc_w), 32'd0);

        // Release between edges and count up 0..9,0.
        #6;
        reset = 1'b0;
        en_w  = 1'b1;
        up_w  = 1'b1;
        #1;
        chk("up0 w.tc", 32'(tc_w), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_w($sformatf("up%0d", i), i % 10, (i == 10), (i >= 10));
            chk($sformatf("up%0d w.tc", i), 32'(tc_w), 32'((i % 10) == 9));
        end

        // Load 0 with en=1: load wins, ovf stays sticky.
        load_w = 1'b1; lv_w = 4'd0;
        tick();
        chk_w("ld0", 0, 0, 1);

        // Count down from 0: wraps to 9.
        load_w = 1'b0; up_w = 1'b0;
        #1;
        chk("dn0 w.tc", 32'(tc_w), 32'd1);
        tick(); chk_w("dn1", 9, 1, 1);
        chk("dn1 w.tc", 32'(tc_w), 32'd0);
        tick(); chk_w("dn2", 8, 0, 1);
        tick(); chk_w("dn3", 7, 0, 1);

        // Hold.
        en_w = 1'b0;
        tick(); chk_w("hold", 7, 0, 1);
        chk("hold w.tc", 32'(tc_w), 32'd0);

        // Load 5 with en=1 up=1: no increment.
        load_w = 1'b1; en_w = 1'b1; up_w = 1'b1; lv_w = 4'd5;
        tick(); chk_w("ld5", 5, 0, 1);

        // clr_ovf alone.
        load_w = 1'b0; en_w = 1'b0; clr_w = 1'b1;
        tick(); chk_w("clr1", 5, 0, 0);

        // Out-of-range load clamps to 9 and sets ovf.
        clr_w = 1'b0; load_w = 1'b1; lv_w = 4'd12;
        tick(); chk_w("ld12", 9, 0, 1);

        // clr_ovf on the same edge as a wrap: set wins.
        load_w = 1'b0; clr_w = 1'b1; en_w = 1'b1; up_w = 1'b1;
        #1;
        chk("wrapclr w.tc", 32'(tc_w), 32'd1);
        tick(); chk_w("wrapclr", 0, 1, 1);

        // clr_ovf alone on the next edge.
        en_w = 1'b0;
        tick(); chk_w("clr2", 0, 0, 0);

        // Get q=6 with ovf=1.
        clr_w = 1'b0; load_w = 1'b1; lv_w = 4'd12;
        tick(); chk_w("ld12b", 9, 0, 1);
        lv_w = 4'd6;
        tick(); chk_w("ld6", 6, 0, 1);

        // Asynchronous reset mid-cycle.
        load_w = 1'b0; en_w = 1'b1; up_w = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk_w("arst", 0, 0, 0);
        tick(); chk_w("arst_hold", 0, 0, 0);
        #2;
        reset = 1'b0;
        tick(); chk_w("resume1", 1, 0, 0);
        tick(); chk_w("resume2", 2, 0, 0);
        en_w = 1'b0;

        // Saturate mode: from 7 up -> 8, 9, 9, 9.
        load_s = 1'b1; lv_s = 4'd7;
        tick(); chk_s("sld7", 7, 0, 0);
        load_s = 1'b0; en_s = 1'b1; up_s = 1'b1;
        tick(); chk_s("sup1", 8, 0, 0);
        tick(); chk_s("sup2", 9, 0, 0);
        chk("sup2 s.tc", 32'(tc_s), 32'd1);
        tick(); chk_s("sup3", 9, 0, 1);
        tick(); chk_s("sup4", 9, 0, 1);
        up_s = 1'b0;
        tick(); chk_s("sdn1", 8, 0, 1);

        // Saturate at 0 going down, with clr on the same edge: set wins.
        load_s = 1'b1; lv_s = 4'd0;
        tick(); chk_s("sld0", 0, 0, 1);
        load_s = 1'b0; clr_s = 1'b1;
        #1;
        chk("sdn0 s.tc", 32'(tc_s), 32'd1);
        tick(); chk_s("sdn0", 0, 0, 1);
        en_s = 1'b0;
        tick(); chk_s("sclr", 0, 0, 0);
        clr_s = 1'b0;

        // Power-of-two modulus: full-range wrap in both directions.
        en_p = 1'b1; up_p = 1'b0;
        #1;
        chk("pdn tc", 32'(tc_p), 32'd1);
        tick(); chk_p("pdn", 7, 1, 1);
        up_p = 1'b1;
        #1;
        chk("pup tc", 32'(tc_p), 32'd1);
        tick(); chk_p("pup", 0, 1, 1);
        tick(); chk_p("pup2", 1, 0, 1);
        en_p = 1'b0;

        // dut_w held untouched through the other phases.
        chk_w("w_idle", 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised synchronous modulo counter: the next generation of the team's 4-bit ripple counter. It adds configurable width and modulus, up/down direction, synchronous load, count enable, wrap or saturate mode, a terminal-count output for cascading, and sticky overflow status. All flops are clocked on the rising edge of one clock, so there is no bit-to-bit ripple. It serves as the general event/timebase counter in the datapath. Instances cascade via `tc` into the next stage's `en`.

## Interface
- `WIDTH`, default 4: counter width in bits; 1 ≤ WIDTH ≤ 32.
- `MODULUS`, default 16: count range is 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- `SATURATE`, default 0: 0 = wrap mode, 1 = saturate mode.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `en`  in  1  count enable; the counter steps by one when high.
- `up`  in  1  direction; 1 = increment, 0 = decrement.
- `load`  in  1  synchronous load strobe; takes priority over `en`.
- `load_val`  in  WIDTH  value loaded when `load` = 1.
- `clr_ovf`  in  1  synchronous clear of `ovf`.
- `q`  out  WIDTH  current count (registered).
- `tc`  out  1  terminal count (combinational).
- `wrap`  out  1  one-cycle pulse, registered.
- `ovf`  out  1  sticky overflow flag, registered.

## Operation
- Reset values: `q` = 0, `wrap` = 0, `ovf` = 0. `tc` follows its equation.
- Per-edge priority is `load` > `en` > hold.
- **Load:** `q` ← `load_val` if `load_val` < MODULUS.
  - Otherwise `q` ← MODULUS-1 and `ovf` is set.
  - `wrap` = 0 on a load cycle.
- **Enable, up = 1:** if `q` < MODULUS-1, `q` ← `q`+1.
  - At MODULUS-1 in wrap mode: `q` ← 0, `wrap` ← 1, `ovf` set.
  - At MODULUS-1 in saturate mode: `q` holds, `wrap` ← 0, `ovf` set.
- **Enable, up = 0:** if `q` > 0, `q` ← `q`-1.
  - At 0 in wrap mode: `q` ← MODULUS-1, `wrap` ← 1, `ovf` set.
  - At 0 in saturate mode: `q` holds, `ovf` set.
- **Terminal count:** `tc` = `en` & (`up` ? `q` == MODULUS-1 : `q` == 0).
  - `tc` is purely combinational and has no registered delay.
- **Flag registers:**
  - `wrap` is 0 on every edge without a wrap event.
  - `ovf` is cleared by `clr_ovf` and set by any set event.
  - If set and clear occur on the same edge, set wins.
- `q` never leaves 0..MODULUS-1 under any input sequence.
- Arithmetic is done in WIDTH+1 bits internally, so MODULUS = 2^WIDTH cannot overflow the compare.
- Direction may change on any cycle; the new direction applies at that edge.

## Timing
- Latency is one cycle: `en`, `load` and `up` sampled at edge N are reflected in `q` after edge N.
- `wrap` is high for exactly the one cycle in which `q` shows the wrapped value.
- `ovf` rises after the same edge on which the event occurs.
- **Reset mid-operation:** `q`, `wrap` and `ovf` clear immediately, without waiting for a clock edge.
  - While `reset` is high, all inputs are ignored.
  - The first update is on the first rising edge sampled with `reset` low.
- **Cascading:** stage k+1 `en` = stage k `tc`. The chain advances in the same cycle with no ripple delay.
- The critical path is the compare plus adder of WIDTH+1 bits; there are no multicycle paths.

## Structure
- Shared package `counter_pkg` holds:
  - the mode constants `CNT_MODE_WRAP` = 0 and `CNT_MODE_SAT` = 1;
  - the next-state result struct (next_q, wrap_evt, ovf_evt).
- Sub-module `mod_counter_next` is combinational. It takes `q`, `en`, `up`, `load`, `load_val` and the parameters, and returns the next-state struct.
- The top level holds only the three registers, the `tc` equation and the `ovf` set/clear logic.

## Test plan
- WIDTH = 4, MODULUS = 10, wrap mode, reset then `en` = 1, `up` = 1 → `q` goes 0,1,…,9,0.
  - `tc` = 1 only while `q` = 9.
  - `wrap` = 1 only in the cycle `q` = 0 after 9.
  - `ovf` = 1 from that cycle on.
- Same configuration, `load` `load_val` = 0, then `up` = 0, `en` = 1 → `q` goes 9,8,…, with `wrap` pulsing when `q` becomes 9.
- SATURATE = 1, MODULUS = 10, count up from 7 → `q` goes 8, 9, 9, 9; `wrap` stays 0; `ovf` rises after the first blocked step.
- `load` = 1, `en` = 1, `load_val` = 5 → `q` = 5 with no increment. Then `load_val` = 12 → `q` = 9 and `ovf` = 1.
- `clr_ovf` = 1 on the same edge as a wrap → `ovf` stays 1. `clr_ovf` alone on the next edge → `ovf` = 0.
- Assert `reset` mid-cycle while `q` = 6 and `ovf` = 1 → `q` = 0 and `ovf` = 0 before the next edge.
  - After release, counting resumes 1, 2, … on subsequent edges.
